// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU plus iterative multiply/divide unit.
// clk/rst_n, in_valid/in_ready/flush, ALUControl/SrcA/SrcB -> out_valid/ALUResult/zero.
module alu_muldiv #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [4:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            out_valid,
  output logic [XLEN-1:0] ALUResult,
  output logic            zero
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_SLL    = 5'd4;
  localparam logic [4:0] OP_SLT    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_XOR    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_LUI    = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, MUL, DIV, DONE
  } state_t;

  state_t state, state_n;

  logic [SHW-1:0]    sh;
  logic              is_mul, is_div, quot;
  logic              sa_op, sb_op;
  logic              a_neg, b_neg;
  logic              div0, ovf, fast_path;
  logic              accept, last;
  logic [XLEN-1:0]   mag_a, mag_b, fast;

  logic [2*XLEN-1:0] acc, mc, acc_add, prod;
  logic [XLEN-1:0]   mp;
  logic [SHW-1:0]    cnt;
  logic [4:0]        op_q;
  logic              neg_q, neg_r, zpend;
  logic [XLEN:0]     rs, diff;
  logic [XLEN-1:0]   r_n, q_n, q_fix, r_fix;
  logic [XLEN-1:0]   mul_res, div_res;

  assign sh        = SrcB[SHW-1:0];
  assign in_ready  = (state == IDLE) ||
                     (state == DONE);
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready && !flush;
  assign last      = cnt == SHW'(XLEN-1);

  always_comb begin
    is_mul = (ALUControl >= OP_MUL) &&
             (ALUControl <= OP_MULHU);
    is_div = (ALUControl >= OP_DIV) &&
             (ALUControl <= OP_REMU);
    quot   = (ALUControl == OP_DIV) ||
             (ALUControl == OP_DIVU);
    sa_op  = ALUControl inside
             {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    sb_op  = ALUControl inside
             {OP_MULH, OP_DIV, OP_REM};
    a_neg  = sa_op && SrcA[XLEN-1];
    b_neg  = sb_op && SrcB[XLEN-1];
    mag_a  = a_neg ? -SrcA : SrcA;
    mag_b  = b_neg ? -SrcB : SrcB;
    div0   = SrcB == '0;
    ovf    = ((ALUControl == OP_DIV) ||
              (ALUControl == OP_REM)) &&
             (SrcA == MIN_NEG) && (SrcB == '1);
    // Only non-special mul/div ops take the iterative path.
    fast_path = !is_mul && !(is_div && !div0 && !ovf);
  end

  always_comb begin
    fast = '0;
    unique case (ALUControl)
      OP_ADD:  fast = SrcA + SrcB;
      OP_SUB:  fast = SrcA - SrcB;
      OP_AND:  fast = SrcA & SrcB;
      OP_OR:   fast = SrcA | SrcB;
      OP_SLL:  fast = SrcA << sh;
      OP_SLT:  fast = {{(XLEN-1){1'b0}},
                       $signed(SrcA) < $signed(SrcB)};
      OP_SRL:  fast = SrcA >> sh;
      OP_SRA:  fast = $signed(SrcA) >>> sh;
      OP_XOR:  fast = SrcA ^ SrcB;
      OP_SLTU: fast = {{(XLEN-1){1'b0}}, SrcA < SrcB};
      OP_LUI:  fast = SrcB << 12;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU:
        fast = div0 ? (quot ? '1 : SrcA)
                    : (quot ? SrcA : '0);
      default: fast = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (accept) begin
          if (is_mul)
            state_n = MUL;
          else if (!fast_path)
            state_n = DIV;
          else
            state_n = DONE;
        end
      end
      MUL:     if (last) state_n = DONE;
      DIV:     if (last) state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // acc holds the product for MUL and {rem, quot} for DIV.
  always_comb begin
    acc_add = acc + (mp[0] ? mc : '0);
    prod    = neg_q ? -acc_add : acc_add;
    mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0]
                               : prod[2*XLEN-1:XLEN];
    rs      = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = rs - {1'b0, mp};
    r_n     = diff[XLEN] ? rs[XLEN-1:0]
                         : diff[XLEN-1:0];
    q_n     = {acc[XLEN-2:0], ~diff[XLEN]};
    q_fix   = neg_q ? -q_n : q_n;
    r_fix   = neg_r ? -r_n : r_n;
    div_res = ((op_q == OP_DIV) || (op_q == OP_DIVU))
              ? q_fix : r_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      mc        <= '0;
      mp        <= '0;
      cnt       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      zpend     <= 1'b0;
      ALUResult <= '0;
      zero      <= 1'b0;
    end else if (accept) begin
      op_q  <= ALUControl;
      zpend <= SrcA == SrcB;
      cnt   <= '0;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      mp    <= mag_b;
      if (is_mul) begin
        acc <= '0;
        mc  <= {{XLEN{1'b0}}, mag_a};
      end else begin
        acc <= {{XLEN{1'b0}}, mag_a};
        mc  <= '0;
      end
      if (fast_path) begin
        ALUResult <= fast;
        zero      <= SrcA == SrcB;
      end
    end else if (!flush &&
                 (state == MUL || state == DIV)) begin
      cnt <= cnt + SHW'(1);
      if (state == MUL) begin
        acc <= acc_add;
        mc  <= mc << 1;
        mp  <= mp >> 1;
      end else begin
        acc <= {r_n, q_n};
      end
      if (last) begin
        ALUResult <= (state == MUL) ? mul_res : div_res;
        zero      <= zpend;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors for alu_muldiv (XLEN=32).
// Checks results, zero flag, latency, in_ready, flush and reset.
module tb_alu_muldiv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [4:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic [31:0] ALUResult;
  logic        zero;

  int n_chk  = 0;
  int n_fail = 0;

  alu_muldiv #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .ALUResult  (ALUResult),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag,
                        input logic [4:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int exp_lat);
    int lat;
    int lowrdy;
    bit got;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    lat    = 1;
    lowrdy = 0;
    got    = 1'b0;
    while (!got && lat < 100) begin
      if (out_valid) got = 1'b1;
      else begin
        if (!in_ready) lowrdy++;
        step();
        lat++;
      end
    end
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " busy"}, lowrdy, exp_lat - 1);
    chk({tag, " res"}, ALUResult, exp);
    chk({tag, " zero"}, zero, a == b);
    step();
    chk({tag, " pulse"}, out_valid, 0);
    chk({tag, " hold"}, ALUResult, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    flush      = 1'b0;
    ALUControl = '0;
    SrcA       = '0;
    SrcB       = '0;
    repeat (3) step();
    chk("rst ready", in_ready, 1);
    chk("rst valid", out_valid, 0);
    chk("rst res", ALUResult, 0);
    chk("rst zero", zero, 0);
    rst_n = 1'b1;

    run_op("add_ovf", 0, 32'h7FFFFFFF, 1,
           32'h80000000, 1);
    run_op("add_eq", 0, 5, 5, 32'hA, 1);
    run_op("sub", 1, 5, 7, 32'hFFFFFFFE, 1);
    run_op("and", 2, 32'hF0F0F0F0, 32'hFF00FF00,
           32'hF000F000, 1);
    run_op("or", 3, 32'hF0F0F0F0, 32'h0F0F0000,
           32'hFFFFF0F0, 1);
    run_op("sll", 4, 1, 32'h3F, 32'h80000000, 1);
    run_op("slt", 5, 32'hFFFFFFFF, 1, 1, 1);
    run_op("srl", 6, 32'h80000000, 4,
           32'h08000000, 1);
    run_op("sra", 7, 32'h80000000, 4,
           32'hF8000000, 1);
    run_op("xor", 8, 32'hFFFF0000, 32'h0F0F0F0F,
           32'hF0F00F0F, 1);
    run_op("sltu_a", 9, 32'hFFFFFFFF, 1, 0, 1);
    run_op("sltu_b", 9, 1, 32'hFFFFFFFF, 1, 1);
    run_op("lui", 10, 0, 32'h12345,
           32'h12345000, 1);
    run_op("op20", 20, 5, 5, 0, 1);
    run_op("op31", 31, 1, 2, 0, 1);

    run_op("mul", 11, 7, 6, 32'h2A, 33);
    run_op("mul_ff", 11, 32'hFFFFFFFF, 32'hFFFFFFFF,
           1, 33);
    run_op("mulh", 12, 32'hFFFFFFFF, 2,
           32'hFFFFFFFF, 33);
    run_op("mulh_min", 12, 32'h80000000,
           32'h80000000, 32'h40000000, 33);
    run_op("mulhsu", 13, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFF, 33);
    run_op("mulhsu_p", 13, 2, 32'hFFFFFFFF, 1, 33);
    run_op("mulhu", 14, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 33);

    run_op("div_ovf", 15, 32'h80000000,
           32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", 17, 32'h80000000,
           32'hFFFFFFFF, 0, 1);
    run_op("divu_0", 16, 100, 0, 32'hFFFFFFFF, 1);
    run_op("remu_0", 18, 100, 0, 32'h64, 1);
    run_op("div_00", 15, 0, 0, 32'hFFFFFFFF, 1);
    run_op("rem_n7", 17, 32'hFFFFFFF9, 2,
           32'hFFFFFFFF, 33);
    run_op("div_n7", 15, 32'hFFFFFFF9, 2,
           32'hFFFFFFFD, 33);
    run_op("divu", 16, 100, 7, 32'hE, 33);
    run_op("remu", 18, 100, 7, 2, 33);
    run_op("div_nb", 15, 7, 32'hFFFFFFFE,
           32'hFFFFFFFD, 33);
    run_op("rem_nb", 17, 7, 32'hFFFFFFFE, 1, 33);
    run_op("div_min", 15, 32'h80000000, 2,
           32'hC0000000, 33);
    run_op("divu_ff", 16, 32'hFFFFFFFF, 16,
           32'h0FFFFFFF, 33);
    run_op("remu_ff", 18, 32'hFFFFFFFF, 16,
           32'hF, 33);

    // back-to-back accept while in DONE
    ALUControl = 0;
    SrcA = 1;
    SrcB = 2;
    in_valid = 1'b1;
    step();
    chk("b2b v1", out_valid, 1);
    chk("b2b r1", ALUResult, 3);
    ALUControl = 1;
    SrcA = 9;
    SrcB = 4;
    step();
    in_valid = 1'b0;
    chk("b2b v2", out_valid, 1);
    chk("b2b r2", ALUResult, 5);
    step();
    chk("b2b end", out_valid, 0);

    run_op("pre", 0, 32'h11, 32'h22, 32'h33, 1);

    // flush beats in_valid in IDLE
    ALUControl = 0;
    SrcA = 1;
    SrcB = 1;
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("fpri valid", out_valid, 0);
    chk("fpri res", ALUResult, 32'h33);

    // flush mid-divide
    ALUControl = 16;
    SrcA = 1000;
    SrcB = 3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fl busy", in_ready, 0);
    repeat (8) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("fl novalid", seen, 0);
    chk("fl res", ALUResult, 32'h33);
    chk("fl zero", zero, 0);

    // reset mid-divide
    ALUControl = 16;
    SrcA = 1000;
    SrcB = 3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("rs busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rs res", ALUResult, 0);
    chk("rs zero", zero, 0);
    chk("rs valid", out_valid, 0);
    chk("rs ready", in_ready, 1);
    step();
    rst_n = 1'b1;

    run_op("add_post", 0, 2, 3, 5, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
